// File: rtl/multi_pulse_generator.sv
// Multi-channel periodic pulse/PWM generator: one shared period counter, per-channel
// duty thresholds, shadow config applied at period boundaries, continuous and one-shot modes.

module mpg_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             load,
    input  logic             run_n,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [WIDTH-1:0] cnt_n,
    output logic             signal
);
    logic [WIDTH-1:0] d_s, d_a, d_s_n, d_a_n;

    // Same-edge cfg writes bypass straight into the active threshold on a load.
    assign d_s_n = cfg_we ? cfg_duty : d_s;
    assign d_a_n = load ? d_s_n : d_a;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_s    <= '0;
            d_a    <= '0;
            signal <= 1'b0;
        end else begin
            d_s    <= d_s_n;
            d_a    <= d_a_n;
            signal <= run_n && (cnt_n < d_a_n);
        end
    end
endmodule

module multi_pulse_generator #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      oneshot,
    input  logic                      start,
    input  logic                      cfg_we,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
    output logic [CHANNELS-1:0]       signal,
    output logic                      period_end,
    output logic                      busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] p_s, p_a, p_s_n, p_a_n;
    logic             mode_q, mode_n;
    logic             load;
    logic             run_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= 1'b0;
            p_s        <= '0;
            p_a        <= '0;
            period_end <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mode_q     <= mode_n;
            p_s        <= p_s_n;
            p_a        <= p_a_n;
            period_end <= run_n && (cnt_n == p_a_n);
            busy       <= run_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if ((!oneshot && enable) || (oneshot && start)) begin
                    state_n = RUN;
                    mode_n  = oneshot;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == p_a) begin
                    cnt_n = '0;
                    // Continuous runs keep going only if enable is high at the boundary.
                    if (!mode_q && enable) load = 1'b1;
                    else                   state_n = IDLE;
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign run_n = (state_n == RUN);
    assign p_s_n = cfg_we ? cfg_period : p_s;
    assign p_a_n = load ? p_s_n : p_a;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mpg_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (cfg_we),
            .load     (load),
            .run_n    (run_n),
            .cfg_duty (cfg_duty[i*WIDTH +: WIDTH]),
            .cnt_n    (cnt_n),
            .signal   (signal[i])
        );
    end
endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: vector table, hand-written corner sequences and
// randomized traffic against a period-level reference model.

module tb_multi_pulse_generator;
    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset, enable, oneshot, start, cfg_we;
    logic [W-1:0]   cfg_period;
    logic [C*W-1:0] cfg_duty;
    logic [C-1:0]   signal;
    logic           period_end, busy;

    int checks = 0;
    int failures = 0;

    multi_pulse_generator #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .start(start),
        .cfg_we(cfg_we), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .signal(signal), .period_end(period_end), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: run flag, position within period, latched mode, shadow/active config.
    int m_run, m_pos, m_mode, m_ps, m_pa;
    int m_ds[C], m_da[C];

    function automatic int exp_sig();
        int s = 0;
        for (int i = 0; i < C; i++)
            if (m_run != 0 && m_pos < m_da[i]) s |= (1 << i);
        return s;
    endfunction

    task automatic model_step();
        int nps;
        int nds[C];
        bit go;
        if (!reset) begin
            m_run = 0; m_pos = 0; m_mode = 0; m_ps = 0; m_pa = 0;
            for (int i = 0; i < C; i++) begin m_ds[i] = 0; m_da[i] = 0; end
            return;
        end
        nps = cfg_we ? int'(cfg_period) : m_ps;
        for (int i = 0; i < C; i++) nds[i] = cfg_we ? int'(cfg_duty[i*W +: W]) : m_ds[i];
        go = 0;
        if (m_run == 0) begin
            if ((!oneshot && enable) || (oneshot && start)) begin
                m_run = 1; m_mode = int'(oneshot); go = 1;
            end
        end else if (m_pos == m_pa) begin
            if (m_mode == 0 && enable) go = 1;
            else m_run = 0;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (go) begin
            m_pos = 0; m_pa = nps;
            for (int i = 0; i < C; i++) m_da[i] = nds[i];
        end
        m_ps = nps;
        for (int i = 0; i < C; i++) m_ds[i] = nds[i];
    endtask

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_signal", int'(signal), exp_sig());
        chk("model_period_end", int'(period_end), (m_run != 0 && m_pos == m_pa) ? 1 : 0);
        chk("model_busy", int'(busy), m_run);
    endtask

    task automatic wait_cnt(input int t);
        for (int k = 0; k < 40 && !(m_run != 0 && m_pos == t); k++) tick();
        if (!(m_run != 0 && m_pos == t)) begin
            checks++; failures++;
            $display("FAIL wait_cnt timeout target=%0d", t);
        end
    endtask

    typedef struct {
        logic         rst, en, os, st, we;
        logic [W-1:0] p;
        logic [C*W-1:0] d;
        logic [C-1:0] sig;
        logic         pe, b;
    } vec_t;

    vec_t tbl[13];
    int nb, ns, np;

    initial begin
        reset = 0; enable = 0; oneshot = 0; start = 0; cfg_we = 0;
        cfg_period = '0; cfg_duty = '0;
        m_run = 0; m_pos = 0; m_mode = 0; m_ps = 0; m_pa = 0;
        for (int i = 0; i < C; i++) begin m_ds[i] = 0; m_da[i] = 0; end

        // Reset with enable/start high, then continuous PWM P=4, D={9,3,1,0}.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 32'h0903_0100, 4'b1110, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h0903_0100, 4'b1100, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h0903_0100, 4'b1100, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h0903_0100, 4'b1000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h0903_0100, 4'b1000, 1'b1, 1'b1};
        for (int i = 8; i < 13; i++) begin
            tbl[i] = tbl[i-5];
            tbl[i].we = 1'b0;
        end

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; oneshot = tbl[i].os; start = tbl[i].st;
            cfg_we = tbl[i].we; cfg_period = tbl[i].p; cfg_duty = tbl[i].d;
            tick();
            chk($sformatf("tbl%0d_signal", i), int'(signal), int'(tbl[i].sig));
            chk($sformatf("tbl%0d_period_end", i), int'(period_end), int'(tbl[i].pe));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
        end
        cfg_we = 0; start = 0;

        // Shadow write mid-period: D[1]=2 written at cnt=2 takes effect next period.
        wait_cnt(2);
        cfg_we = 1; cfg_period = 8'd4; cfg_duty = 32'h0903_0200;
        tick(); cfg_we = 0; chk("shadow_cnt3", int'(signal[1]), 0);
        tick(); chk("shadow_cnt4", int'(signal[1]), 0);
        tick(); chk("shadow_cnt0", int'(signal[1]), 1);
        tick(); chk("shadow_cnt1", int'(signal[1]), 1);
        tick(); chk("shadow_cnt2", int'(signal[1]), 0);

        // Graceful stop: enable dropped at cnt=1, period still completes.
        wait_cnt(1);
        enable = 0;
        tick(); chk("stop_busy_cnt2", int'(busy), 1);
        tick(); chk("stop_busy_cnt3", int'(busy), 1);
        tick(); chk("stop_busy_cnt4", int'(busy), 1);
        chk("stop_pe_cnt4", int'(period_end), 1);
        tick(); chk("stop_busy_after", int'(busy), 0);
        chk("stop_signal_after", int'(signal), 0);
        enable = 1;
        tick(); chk("restart_busy", int'(busy), 1);

        // Drop at cnt=1, re-assert at cnt=3: seamless next period.
        wait_cnt(1);
        enable = 0;
        tick(); tick();
        enable = 1;
        tick(); chk("resume_pe_cnt4", int'(period_end), 1);
        tick(); chk("resume_busy_cnt0", int'(busy), 1);
        chk("resume_signal_cnt0", int'(signal), 4'b1110);

        // One-shot P=2, D[0]=1, config written on the start edge; second start ignored.
        enable = 0;
        for (int k = 0; k < 20 && m_run != 0; k++) tick();
        chk("oneshot_idle_before", int'(busy), 0);
        oneshot = 1; start = 1; cfg_we = 1; cfg_period = 8'd2; cfg_duty = 32'h0000_0001;
        nb = 0; ns = 0; np = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = (k == 0); cfg_we = 0;
            nb += int'(busy); ns += int'(signal[0]); np += int'(period_end);
        end
        chk("oneshot_busy_cycles", nb, 3);
        chk("oneshot_ch0_cycles", ns, 1);
        chk("oneshot_period_ends", np, 1);
        chk("oneshot_idle_after", int'(busy), 0);
        oneshot = 0; start = 0;

        // P=0: one-cycle period, ch0 and period_end constantly high.
        cfg_we = 1; cfg_period = 8'd0; cfg_duty = 32'h0000_0001; enable = 1;
        tick(); cfg_we = 0;
        for (int k = 0; k < 5; k++) begin
            chk("p0_ch0", int'(signal[0]), 1);
            chk("p0_pe", int'(period_end), 1);
            tick();
        end

        // Reset mid-run at cnt=2.
        cfg_we = 1; cfg_period = 8'd4; cfg_duty = 32'h0903_0100;
        tick(); cfg_we = 0;
        wait_cnt(2);
        reset = 0;
        tick();
        chk("midreset_signal", int'(signal), 0);
        chk("midreset_pe", int'(period_end), 0);
        chk("midreset_busy", int'(busy), 0);
        reset = 1; enable = 0;
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            reset   = ($urandom_range(0, 79) != 0);
            enable  = ($urandom_range(0, 3) != 0);
            oneshot = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 4) == 0);
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_period = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            for (int i = 0; i < C; i++) cfg_duty[i*W +: W] = W'($urandom_range(0, 8));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_pulse_generator.md
# multi_pulse_generator

Parametrised multi-channel periodic pulse/PWM generator: the programmable, multi-output successor of the fixed 1-in-5 pulse generator. It has one shared period counter and CHANNELS independent duty thresholds. Configuration goes through shadow registers that take effect only at a period boundary. It supports continuous (level-enabled, graceful stop) and one-shot (single period on a start strobe) modes, and drives timing strobes for downstream logic.

## Interface
- WIDTH, 8, bit width of the counter, period and each duty value
- CHANNELS, 4, number of independent pulse outputs
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- enable  input  1  continuous mode run request (level)
- oneshot  input  1  mode select: 0 = continuous, 1 = one-shot; sampled only at run entry
- start  input  1  one-shot trigger strobe, honoured only in IDLE with oneshot=1
- cfg_we  input  1  write strobe for the shadow configuration
- cfg_period  input  WIDTH  shadow value P; period length is P+1 cycles
- cfg_duty  input  CHANNELS*WIDTH  shadow duty D[i], channel i in bits [i*WIDTH +: WIDTH]
- signal  output  CHANNELS  pulse outputs, registered
- period_end  output  1  high in the last cycle of each period, registered
- busy  output  1  high while in RUN, registered

## Operation
- Storage:
  - shadow regs (P_s, D_s[i]) are written on any edge with cfg_we=1, in any state.
  - active regs (P_a, D_a[i]) drive the outputs.
  - counter cnt is WIDTH bits wide.
  - mode_q holds the mode latched at run entry.
- States: IDLE and RUN.
- IDLE → RUN on an edge where either condition holds:
  - oneshot=0 and enable=1;
  - oneshot=1 and start=1.
- On IDLE → RUN entry:
  - cnt←0, mode_q←oneshot.
  - active←shadow. If cfg_we=1 on the same edge, the incoming cfg values are loaded directly (bypass).
- In RUN, cnt increments each cycle. When cnt==P_a, the next cycle is a boundary:
  - continuous, enable=1: cnt←0, active←shadow (with the same bypass rule), stay in RUN.
  - continuous, enable=0: go to IDLE (graceful stop; the current period always completes).
  - one-shot: go to IDLE after exactly one period. start is ignored throughout RUN.
- enable changes mid-period have no effect until the boundary. Re-asserting enable before cnt==P_a continues the run seamlessly.
- Output decode, in cycles where busy=1:
  - signal[i] = (cnt < D_a[i]);
  - period_end = (cnt == P_a).
- Decode edge cases:
  - D=0 → channel always low.
  - D>P → channel always high for the whole period.
  - P=0 → period is 1 cycle, so period_end is constantly 1 while running.
- Comparisons are unsigned, WIDTH bits. cnt never exceeds P_a, so no wrap beyond P_a.
- In IDLE: signal=0, period_end=0, busy=0, and cnt is held at 0.

## Timing
- Outputs are registers computed from next-state. Their values in any cycle reflect the cnt/state held in that same cycle; there is no extra lag.
- Run entry latency: entry condition sampled on edge t → busy=1, cnt=0 and signal=(0<D) are visible from edge t onward.
- Run exit: on the edge after the cnt==P_a cycle, busy, signal and period_end drop to 0.
- Shadow writes take effect at the next period start, never mid-period.
- Reset (reset=0 sampled on an edge) overrides everything, including mid-run. Values on the following cycle:
  - state=IDLE, cnt=0, mode_q=0;
  - P_s=P_a=0, all D=0;
  - signal=0, period_end=0, busy=0.
- Simultaneous start and cfg_we in IDLE: the new config is used for that first period.

## Test plan
- Reset: reset=0 for 3 cycles with enable=1 and start=1 → signal=4'b0000, busy=0, period_end=0 throughout. Release → entry on the next edge.
- Continuous PWM:
  - stimulus: cfg P=4, D={9,3,1,0} (ch3..ch0), enable=1;
  - required response: 5-cycle period, period_end at cnt=4, ch0 never high, ch1 high 1/5 cycles (cnt 0), ch2 high at cnt 0..2, ch3 constantly high.
- Shadow timing:
  - stimulus: while running with P=4, write D[1]=2 when cnt=2;
  - required response: ch1 keeps its 1-cycle pulse for the rest of that period, then goes high at cnt 0..1 from the next period on.
- One-shot:
  - stimulus: oneshot=1, P=2, D[0]=1, one start pulse, then a second start while busy;
  - required response: busy high exactly 3 cycles, ch0 high 1 cycle, one period_end, return to IDLE; the second start is ignored.
- Graceful stop and restart:
  - stimulus: with P=4, drop enable at cnt=1;
  - required response: the run continues through cnt=4 and busy falls on the next edge;
  - re-asserting enable at cnt=3 instead → no gap, next period starts at cnt=0.
- Corners:
  - P=0, D[0]=1 → ch0 constantly 1, period_end=1 every cycle;
  - reset=0 mid-run at cnt=2 → all outputs 0 on the next cycle.
